// File: rtl/interrupt_priority_unit.sv
// Request capture, fully-nested priority resolution with a rotatable pointer,
// and in-service tracking for the stage in front of the PIC control logic.
module interrupt_priority_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ir,
    input  logic       level_mode,
    input  logic [7:0] imr,
    input  logic       freeze,
    input  logic       ack_first,
    input  logic       ack_second,
    input  logic       auto_eoi,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    output logic       int_request,
    output logic [2:0] int_level,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] lowest_level
);

    logic [7:0] r_sync [SYNC_STAGES];
    logic [7:0] r_irPrev;
    logic [7:0] r_edgePend;
    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [2:0] r_lowest;
    logic       r_intReq;
    logic [2:0] r_intLvl;
    logic       r_ackValid;
    logic [2:0] r_ackLvl;

    logic [7:0] w_irSync;
    logic [7:0] w_rise;
    logic [7:0] w_ackSet;
    logic [7:0] w_irrNext;
    logic [7:0] w_isrNext;
    logic [7:0] w_pendNext;
    logic [2:0] w_lowestNext;
    logic [3:0] w_cand;
    logic [3:0] w_isrTop;
    logic [3:0] w_isrHigh;
    logic [2:0] w_candRank;
    logic [2:0] w_isrRank;
    logic       w_winValid;

    // Returns {found, level} of the highest-priority set bit; rank 0 sits just above 'lowest'.
    function automatic logic [3:0] findHighest(input logic [7:0] vec, input logic [2:0] lowest);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            lvl = lowest + 3'(k) + 3'd1;
            if (vec[lvl]) begin
                res = {1'b1, lvl};
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 8'h00;
            end
        end else begin
            r_sync[0] <= ir;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_irSync = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_irSync & ~r_irPrev;
    assign w_ackSet = (ack_first && r_intReq) ? (8'h01 << r_intLvl) : 8'h00;

    always_comb begin
        w_cand     = findHighest(r_irr & ~imr, r_lowest);
        w_isrTop   = findHighest(r_isr & ~imr, r_lowest);
        w_isrHigh  = findHighest(r_isr, r_lowest);
        w_candRank = w_cand[2:0] - r_lowest - 3'd1;
        w_isrRank  = w_isrTop[2:0] - r_lowest - 3'd1;
        w_winValid = w_cand[3] && (!w_isrTop[3] || (w_candRank < w_isrRank));
    end

    // Edges seen while frozen accumulate in r_edgePend and land once freeze drops.
    always_comb begin
        w_pendNext = 8'h00;
        w_irrNext  = r_irr;
        if (freeze) begin
            w_pendNext = r_edgePend | w_rise;
        end else if (level_mode) begin
            w_irrNext = w_irSync;
        end else begin
            w_irrNext = r_irr | w_rise | r_edgePend;
        end
        w_irrNext = w_irrNext & ~w_ackSet;
    end

    // EOI sees the pre-cycle ISR; a same-cycle ack set is OR-ed in last so it wins.
    always_comb begin
        w_isrNext    = r_isr;
        w_lowestNext = r_lowest;
        if (eoi_valid) begin
            if (eoi_specific) begin
                w_isrNext[eoi_level] = 1'b0;
                if (eoi_rotate) begin
                    w_lowestNext = eoi_level;
                end
            end else if (w_isrHigh[3]) begin
                w_isrNext[w_isrHigh[2:0]] = 1'b0;
                if (eoi_rotate) begin
                    w_lowestNext = w_isrHigh[2:0];
                end
            end
        end
        if (ack_second && auto_eoi && r_ackValid) begin
            w_isrNext[r_ackLvl] = 1'b0;
        end
        w_isrNext = w_isrNext | w_ackSet;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irPrev   <= 8'h00;
            r_edgePend <= 8'h00;
            r_irr      <= 8'h00;
            r_isr      <= 8'h00;
            r_lowest   <= 3'd7;
            r_intReq   <= 1'b0;
            r_intLvl   <= 3'd0;
            r_ackValid <= 1'b0;
            r_ackLvl   <= 3'd7;
        end else begin
            r_irPrev   <= w_irSync;
            r_edgePend <= w_pendNext;
            r_irr      <= w_irrNext;
            r_isr      <= w_isrNext;
            r_lowest   <= w_lowestNext;
            if (!freeze) begin
                r_intReq <= w_winValid;
                r_intLvl <= w_winValid ? w_cand[2:0] : 3'd0;
            end
            if (ack_first) begin
                r_ackValid <= r_intReq;
                r_ackLvl   <= r_intReq ? r_intLvl : 3'd7;
            end else if (ack_second) begin
                r_ackValid <= 1'b0;
            end
        end
    end

    assign int_request  = r_intReq;
    assign int_level    = r_intLvl;
    assign irr          = r_irr;
    assign isr          = r_isr;
    assign lowest_level = r_lowest;

endmodule

// File: tb/tb_interrupt_priority_unit.sv
// Directed bench for interrupt_priority_unit: capture latency, nesting, masking,
// rotation, spurious/AEOI acks, freeze edge retention and same-cycle EOI/ack.
module tb_interrupt_priority_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ir = 8'h00;
    logic       level_mode = 1'b0;
    logic [7:0] imr = 8'h00;
    logic       freeze = 1'b0;
    logic       ack_first = 1'b0;
    logic       ack_second = 1'b0;
    logic       auto_eoi = 1'b0;
    logic       eoi_valid = 1'b0;
    logic       eoi_specific = 1'b0;
    logic       eoi_rotate = 1'b0;
    logic [2:0] eoi_level = 3'd0;
    logic       int_request;
    logic [2:0] int_level;
    logic [7:0] irr;
    logic [7:0] isr;
    logic [2:0] lowest_level;

    int checks = 0;
    int errors = 0;

    interrupt_priority_unit #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .level_mode(level_mode), .imr(imr),
        .freeze(freeze), .ack_first(ack_first), .ack_second(ack_second),
        .auto_eoi(auto_eoi), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
        .eoi_rotate(eoi_rotate), .eoi_level(eoi_level), .int_request(int_request),
        .int_level(int_level), .irr(irr), .isr(isr), .lowest_level(lowest_level)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulseAckFirst();
        ack_first = 1'b1;
        step(1);
        ack_first = 1'b0;
    endtask

    task automatic pulseAckSecond();
        ack_second = 1'b1;
        step(1);
        ack_second = 1'b0;
    endtask

    task automatic sendEoi(input logic specific, input logic rotate, input logic [2:0] lvl);
        eoi_valid = 1'b1;
        eoi_specific = specific;
        eoi_rotate = rotate;
        eoi_level = lvl;
        step(1);
        eoi_valid = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate = 1'b0;
        eoi_level = 3'd0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        step(3);
        checks++; if (irr !== 8'h00) begin errors++; $display("[TB] FAIL reset_irr: got %h expected 00", irr); end
        checks++; if (isr !== 8'h00) begin errors++; $display("[TB] FAIL reset_isr: got %h expected 00", isr); end
        checks++; if (int_request !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", int_request); end
        checks++; if (int_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_lvl: got %0d expected 0", int_level); end
        checks++; if (lowest_level !== 3'd7) begin errors++; $display("[TB] FAIL reset_lowest: got %0d expected 7", lowest_level); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_edge_capture();
        ir = 8'h08;
        step(2);
        checks++; if (irr !== 8'h00) begin errors++; $display("[TB] FAIL edge_irr_early: got %h expected 00", irr); end
        step(1);
        checks++; if (irr !== 8'h08) begin errors++; $display("[TB] FAIL edge_irr_3cyc: got %h expected 08", irr); end
        checks++; if (int_request !== 1'b0) begin errors++; $display("[TB] FAIL edge_req_3cyc: got %b expected 0", int_request); end
        step(1);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd3) begin errors++; $display("[TB] FAIL edge_req_4cyc: got %b/%0d expected 1/3", int_request, int_level); end
        ir = 8'h00;
        step(3);
        checks++; if (irr !== 8'h08) begin errors++; $display("[TB] FAIL edge_fall_keeps: got %h expected 08", irr); end
        pulseAckFirst();
        checks++; if (isr !== 8'h08 || irr !== 8'h00) begin errors++; $display("[TB] FAIL edge_ack: got isr %h irr %h expected 08/00", isr, irr); end
        step(1);
        checks++; if (int_request !== 1'b0) begin errors++; $display("[TB] FAIL edge_req_after_ack: got %b expected 0", int_request); end
    endtask

    task automatic test_nesting();
        ir = 8'h20;
        step(5);
        checks++; if (irr !== 8'h20 || int_request !== 1'b0) begin errors++; $display("[TB] FAIL nest_lower_blocked: got irr %h req %b expected 20/0", irr, int_request); end
        ir = 8'h22;
        step(5);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd1) begin errors++; $display("[TB] FAIL nest_higher_wins: got %b/%0d expected 1/1", int_request, int_level); end
        freeze = 1'b1;
        pulseAckFirst();
        step(1);
        checks++; if (isr !== 8'h0a || irr !== 8'h20 || int_request !== 1'b1 || int_level !== 3'd1) begin errors++; $display("[TB] FAIL nest_frozen: got isr %h irr %h req %b lvl %0d expected 0a/20/1/1", isr, irr, int_request, int_level); end
        freeze = 1'b0;
        pulseAckSecond();
        checks++; if (isr !== 8'h0a || int_request !== 1'b0) begin errors++; $display("[TB] FAIL nest_ack2_no_aeoi: got isr %h req %b expected 0a/0", isr, int_request); end
        sendEoi(1'b1, 1'b0, 3'd1);
        checks++; if (isr !== 8'h08) begin errors++; $display("[TB] FAIL nest_spec_eoi: got %h expected 08", isr); end
        sendEoi(1'b0, 1'b0, 3'd0);
        checks++; if (isr !== 8'h00 || lowest_level !== 3'd7) begin errors++; $display("[TB] FAIL nest_ns_eoi: got isr %h lowest %0d expected 00/7", isr, lowest_level); end
        step(1);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd5) begin errors++; $display("[TB] FAIL nest_unblocked: got %b/%0d expected 1/5", int_request, int_level); end
        pulseAckFirst();
        sendEoi(1'b0, 1'b0, 3'd0);
        ir = 8'h00;
        step(4);
    endtask

    task automatic test_level_mask();
        level_mode = 1'b1;
        imr = 8'h04;
        ir = 8'h04;
        step(5);
        checks++; if (irr !== 8'h04 || int_request !== 1'b0) begin errors++; $display("[TB] FAIL level_masked: got irr %h req %b expected 04/0", irr, int_request); end
        imr = 8'h00;
        step(1);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd2) begin errors++; $display("[TB] FAIL level_unmasked: got %b/%0d expected 1/2", int_request, int_level); end
        ir = 8'h00;
        step(3);
        checks++; if (irr !== 8'h00) begin errors++; $display("[TB] FAIL level_drop_irr: got %h expected 00", irr); end
        step(1);
        checks++; if (int_request !== 1'b0) begin errors++; $display("[TB] FAIL level_drop_req: got %b expected 0", int_request); end
        level_mode = 1'b0;
        step(2);
    endtask

    task automatic test_rotation();
        ir = 8'h10;
        step(4);
        pulseAckFirst();
        checks++; if (isr !== 8'h10) begin errors++; $display("[TB] FAIL rot_setup_isr: got %h expected 10", isr); end
        ir = 8'h00;
        step(2);
        sendEoi(1'b0, 1'b1, 3'd0);
        checks++; if (isr !== 8'h00 || lowest_level !== 3'd4) begin errors++; $display("[TB] FAIL rot_ns_eoi: got isr %h lowest %0d expected 00/4", isr, lowest_level); end
        ir = 8'h28;
        step(4);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd5) begin errors++; $display("[TB] FAIL rot_winner: got %b/%0d expected 1/5", int_request, int_level); end
        pulseAckFirst();
        step(1);
        checks++; if (isr !== 8'h20 || int_request !== 1'b0) begin errors++; $display("[TB] FAIL rot_blocked: got isr %h req %b expected 20/0", isr, int_request); end
        sendEoi(1'b1, 1'b1, 3'd5);
        checks++; if (isr !== 8'h00 || lowest_level !== 3'd5) begin errors++; $display("[TB] FAIL rot_spec_eoi: got isr %h lowest %0d expected 00/5", isr, lowest_level); end
        step(1);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd3) begin errors++; $display("[TB] FAIL rot_next: got %b/%0d expected 1/3", int_request, int_level); end
        pulseAckFirst();
        sendEoi(1'b0, 1'b0, 3'd0);
        ir = 8'h00;
        sendEoi(1'b1, 1'b1, 3'd7);
        checks++; if (isr !== 8'h00 || lowest_level !== 3'd7) begin errors++; $display("[TB] FAIL rot_restore: got isr %h lowest %0d expected 00/7", isr, lowest_level); end
        step(3);
    endtask

    task automatic test_spurious_aeoi();
        ir = 8'h80;
        step(4);
        pulseAckFirst();
        ir = 8'h00;
        step(1);
        checks++; if (isr !== 8'h80 || int_request !== 1'b0) begin errors++; $display("[TB] FAIL spur_setup: got isr %h req %b expected 80/0", isr, int_request); end
        auto_eoi = 1'b1;
        pulseAckFirst();
        pulseAckSecond();
        checks++; if (isr !== 8'h80) begin errors++; $display("[TB] FAIL spur_isr_kept: got %h expected 80", isr); end
        sendEoi(1'b0, 1'b0, 3'd0);
        ir = 8'h40;
        step(4);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd6) begin errors++; $display("[TB] FAIL aeoi_req: got %b/%0d expected 1/6", int_request, int_level); end
        freeze = 1'b1;
        pulseAckFirst();
        checks++; if (isr !== 8'h40) begin errors++; $display("[TB] FAIL aeoi_set: got %h expected 40", isr); end
        freeze = 1'b0;
        pulseAckSecond();
        checks++; if (isr !== 8'h00) begin errors++; $display("[TB] FAIL aeoi_clear: got %h expected 00", isr); end
        auto_eoi = 1'b0;
        ir = 8'h00;
        step(3);
    endtask

    task automatic test_freeze_edge();
        freeze = 1'b1;
        ir = 8'h02;
        step(5);
        checks++; if (irr !== 8'h00) begin errors++; $display("[TB] FAIL frz_irr_held: got %h expected 00", irr); end
        freeze = 1'b0;
        step(1);
        checks++; if (irr !== 8'h02) begin errors++; $display("[TB] FAIL frz_edge_applied: got %h expected 02", irr); end
        step(1);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd1) begin errors++; $display("[TB] FAIL frz_req: got %b/%0d expected 1/1", int_request, int_level); end
        pulseAckFirst();
        ir = 8'h00;
        sendEoi(1'b0, 1'b0, 3'd0);
        step(3);
    endtask

    task automatic test_same_cycle_and_reset();
        ir = 8'h04;
        step(4);
        ack_first = 1'b1;
        eoi_valid = 1'b1;
        eoi_specific = 1'b1;
        eoi_level = 3'd2;
        step(1);
        ack_first = 1'b0;
        eoi_valid = 1'b0;
        eoi_specific = 1'b0;
        eoi_level = 3'd0;
        checks++; if (isr !== 8'h04 || irr !== 8'h00) begin errors++; $display("[TB] FAIL same_cycle: got isr %h irr %h expected 04/00", isr, irr); end
        ir = 8'h05;
        step(4);
        checks++; if (int_request !== 1'b1 || int_level !== 3'd0) begin errors++; $display("[TB] FAIL preempt_req: got %b/%0d expected 1/0", int_request, int_level); end
        freeze = 1'b1;
        pulseAckFirst();
        sendEoi(1'b1, 1'b1, 3'd5);
        checks++; if (isr !== 8'h05 || lowest_level !== 3'd5) begin errors++; $display("[TB] FAIL clear_bit_rotate: got isr %h lowest %0d expected 05/5", isr, lowest_level); end
        rst_n = 1'b0;
        #1;
        checks++; if (irr !== 8'h00 || isr !== 8'h00 || int_request !== 1'b0 || int_level !== 3'd0 || lowest_level !== 3'd7) begin errors++; $display("[TB] FAIL mid_inta_reset: got irr %h isr %h req %b lvl %0d lowest %0d expected 00/00/0/0/7", irr, isr, int_request, int_level, lowest_level); end
        ir = 8'h00;
        freeze = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        auto_eoi = 1'b1;
        pulseAckSecond();
        auto_eoi = 1'b0;
        checks++; if (isr !== 8'h00 || int_request !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_ack2: got isr %h req %b expected 00/0", isr, int_request); end
    endtask

    initial begin
        test_reset();
        test_edge_capture();
        test_nesting();
        test_level_mask();
        test_rotation();
        test_spurious_aeoi();
        test_freeze_edge();
        test_same_cycle_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_priority_unit.md
# interrupt_priority_unit

Clocked request-capture and priority-resolution stage that sits directly upstream of the PIC control logic. It latches the eight IR lines into the IRR in edge- or level-triggered mode and applies the IMR. It resolves the highest-priority eligible request under fully-nested rules with a rotatable priority pointer, and drives int_request/int_level to the control logic. It also consumes the control logic's INTA phase pulses and decoded EOI commands to maintain the ISR.

## Interface
- SYNC_STAGES, 2: flip-flop depth of the IR input synchronizer (legal range 2..4).

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- ir  in  8  raw interrupt request lines, asynchronous to clk.
- level_mode  in  1  1 = level-triggered (ICW1 LTIM); 0 = edge-triggered.
- imr  in  8  interrupt mask; 1 = masked.
- freeze  in  1  high between first and second INTA; holds IRR, int_request and int_level.
- ack_first  in  1  single-cycle pulse, first INTA.
- ack_second  in  1  single-cycle pulse, second INTA.
- auto_eoi  in  1  1 = clear the acknowledged ISR bit on ack_second.
- eoi_valid  in  1  single-cycle pulse carrying an OCW2 EOI command.
- eoi_specific  in  1  1 = specific EOI on eoi_level; 0 = non-specific.
- eoi_rotate  in  1  1 = rotate priority on this EOI.
- eoi_level  in  3  target level for specific EOI.
- int_request  out  1  registered request to control logic.
- int_level  out  3  registered winning level, valid while int_request = 1.
- irr  out  8  interrupt request register.
- isr  out  8  in-service register.
- lowest_level  out  3  current lowest-priority level (rotation pointer).

## Operation
- Reset values: irr = 0, isr = 0, int_request = 0, int_level = 0, lowest_level = 7 (IR0 highest), synchronizer and edge-detect registers = 0.
- Priority rank of level i = (i − lowest_level − 1) mod 8. Rank 0 is highest. All arithmetic is 3-bit wrap.
- Edge mode, freeze = 0: a 0→1 transition on the synchronized ir[i] sets irr[i]. The bit stays set until ack_first selects level i. A falling line does not clear it.
- Level mode, freeze = 0: irr tracks synchronized ir every cycle, except that a bit cleared by ack_first stays cleared for that cycle.
- freeze = 1: irr holds, except for the ack_first clear. Edges arriving during freeze are retained in the edge detector and are applied on the first cycle after freeze falls.
- Eligible set = irr & ~imr. The candidate is the highest-rank eligible bit. It wins only if its rank is strictly higher than the highest-rank set isr bit, or if isr = 0. Masked levels are ignored in isr comparison only when imr masks them.
- int_request and int_level update each cycle from the winner when freeze = 0, and hold when freeze = 1.
- ack_first behaviour:
  - With int_request = 1: isr[int_level] <= 1 and irr[int_level] <= 0. Register ack_lvl = int_level.
  - With int_request = 0 (spurious): ack_lvl = 7, no isr change.
- ack_second with auto_eoi = 1 and a non-spurious ack: isr[ack_lvl] <= 0.
- Non-specific EOI: clear the highest-rank set isr bit L. If eoi_rotate = 1, lowest_level <= L. If isr = 0, nothing changes and no rotation occurs.
- Specific EOI: isr[eoi_level] <= 0. If eoi_rotate = 1, lowest_level <= eoi_level, even if the bit was already clear.
- Simultaneous eoi_valid and ack_first in one cycle: the EOI is evaluated on the pre-cycle isr. The ack set is applied after it, so the ack wins on the same bit.

## Timing
- ir rising → synchronized after SYNC_STAGES edges → irr set on the next edge → int_request = 1 on the following edge. Total latency: SYNC_STAGES + 2 cycles.
- ack_first at edge N: isr/irr change at N. int_request re-evaluates at N+1 unless freeze is high, in which case it holds.
- The EOI effect on isr and lowest_level is visible one edge after the eoi_valid cycle. A newly unblocked request raises int_request one edge later.
- rst_n asserted mid-INTA sequence: all state returns to reset values immediately. A later ack_second is treated as spurious (ack_lvl = 7).

## Test plan
- Edge mode, imr = 0, pulse ir[3] → irr = 0x08 after 3 cycles and int_request = 1, int_level = 3 after 4 cycles. Then ack_first → isr = 0x08, irr = 0.
- Nesting: isr = 0x08, then raise ir[5] → int_request stays 0. Raise ir[1] → int_level = 1 asserted.
- Masking/level mode: level_mode = 1, imr = 0x04, hold ir[2] → no int_request. Clear imr → int_level = 2. Drop ir[2] before ack → irr[2] = 0, int_request = 0.
- Rotation: isr = 0x10, non-specific EOI with rotate → isr = 0, lowest_level = 4. Raise ir[3] and ir[5] together → int_level = 5.
- Spurious and AEOI: ack_first with int_request = 0 then ack_second → isr unchanged. With auto_eoi = 1, a real ack of level 6 → isr[6] set then cleared after ack_second.
- Same-cycle EOI (specific, level 2) with ack_first on level 2 → isr[2] = 1. Also assert rst_n low mid-freeze → all outputs at reset values, lowest_level = 7.
